input_port_ctrl: RTL and testbench

- Board-to-CPU input path: the reverse direction of the CPU-output-to-display path.
- Samples the 8 data switches and the "enter" pushbutton, synchronizes both, and debounces the button.
- On each clean press, latches the switch value into a holding register and raises a valid flag.
- The processor consumes the byte with a one-cycle read strobe. The block replaces direct wiring of raw switches to pINPUT.

---
 rtl/input_port_ctrl.sv | 140 ++++++++++++++
 tb/tb_input_port_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/input_port_ctrl.sv
// Switch/button input port: 2-FF syncs, debounced "enter" key, capture into a holding register for the CPU.
// Latency: capture on edge DEBOUNCE_CYCLES+2 after key_n is first sampled low; outputs are registered.
// Backpressure: none; a capture over an unread byte overwrites it and sets the sticky overrun flag.
module input_port_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       key_n,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       press
);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       key_m_q, key_m_d, key_s_q, key_s_d;
  logic [7:0] sw_m_q, sw_m_d, sw_s_q, sw_s_d;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       press_q, press_d;
  logic       capture;

  // Two-stage synchronizers: nothing downstream ever looks at the raw pins.
  always_comb begin
    key_m_d = key_n;
    key_s_d = key_m_q;
    sw_m_d  = sw;
    sw_s_d  = sw_m_q;
  end

  // Debounce FSM: a level must hold for the full window before it is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s_q) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        // Bounce back low during release is the same press: no new capture.
        if (!key_s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register, valid/overrun bookkeeping and the one-cycle press pulse.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    press_d   = capture;
    if (capture) begin
      data_d  = sw_s_q;
      valid_d = 1'b1;
      // A coincident read consumed the old byte, so only an unread one counts as lost.
      if (valid_q && !rd) begin
        overrun_d = 1'b1;
      end
    end else if (rd && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_m_q   <= 1'b1;
      key_s_q   <= 1'b1;
      sw_m_q    <= 8'h00;
      sw_s_q    <= 8'h00;
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      key_m_q   <= key_m_d;
      key_s_q   <= key_s_d;
      sw_m_q    <= sw_m_d;
      sw_s_q    <= sw_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      press_q   <= press_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign press   = press_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: directed scenarios plus random key/switch/read traffic.
// Latency: reference model predicts every output after each clock edge; checked on the falling edge.
// Backpressure: not applicable; rd is driven randomly or at chosen cycles.
module tb_input_port_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       key_n = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, press;

  int n_cmp = 0;
  int n_bad = 0;

  input_port_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .key_n(key_n), .rd(rd),
    .data(data), .valid(valid), .overrun(overrun), .press(press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs reach the debouncer two edges late; the accepted
  // level flips once the opposite level has been seen D+1 edges in a row.
  logic       k1, k2, s_key;
  logic [7:0] s1, s2, s_sw;
  logic       m_pressed, m_cap;
  int         run;
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_press;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k1 = 1'b1; k2 = 1'b1; s1 = 8'h00; s2 = 8'h00;
      m_pressed = 1'b0; run = 0;
      m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_press = 1'b0;
    end else begin
      s_key = k2; s_sw = s2;
      k2 = k1; s2 = s1; k1 = key_n; s1 = sw;
      m_cap = 1'b0;
      if (s_key == !m_pressed) begin
        run = 0;
      end else begin
        run++;
        if (run == D + 1) begin
          m_pressed = !m_pressed;
          run = 0;
          m_cap = m_pressed;
        end
      end
      m_press = m_cap;
      if (m_cap) begin
        if (m_valid && !rd) m_ovr = 1'b1;
        m_data = s_sw;
        m_valid = 1'b1;
      end else if (rd && m_valid) begin
        m_valid = 1'b0;
        m_ovr = 1'b0;
      end
    end
  end

  // Every cycle out of reset, all outputs must match the model.
  always @(negedge clk) begin
    if (rst) begin
      check("data", {24'h0, data}, {24'h0, m_data});
      check("valid", {31'h0, valid}, {31'h0, m_valid});
      check("overrun", {31'h0, overrun}, {31'h0, m_ovr});
      check("press", {31'h0, press}, {31'h0, m_press});
    end
  end

  int press_cnt = 0;
  always @(negedge clk) if (rst && press) press_cnt++;

  // Tasks start and end just after a falling edge.
  task automatic key_hold(input logic [7:0] v, input int n_low, input int n_high);
    sw = v;
    key_n = 1'b0;
    repeat (n_low) @(negedge clk);
    key_n = 1'b1;
    repeat (n_high) @(negedge clk);
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    // Reset with key held and switches set.
    key_n = 1'b0; sw = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_press", {31'h0, press}, 32'h0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_pre_cap", {31'h0, valid}, 32'h0);
    @(negedge clk);
    check("rst_cap_valid", {31'h0, valid}, 32'h1);
    check("rst_cap_data", {24'h0, data}, 32'hA5);
    check("rst_cap_press", {31'h0, press}, 32'h1);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_pulse();

    // Held key: exactly one capture.
    p0 = press_cnt;
    key_hold(8'h3C, 20, 10);
    check("hold_data", {24'h0, data}, 32'h3C);
    check("hold_presses", press_cnt - p0, 1);
    rd_pulse();

    // Short glitch: no capture.
    p0 = press_cnt;
    key_hold(8'hEE, 3, 10);
    check("glitch_valid", {31'h0, valid}, 32'h0);
    check("glitch_presses", press_cnt - p0, 0);

    // Read handshake, extra reads ignored.
    key_hold(8'h11, 8, 10);
    rd_pulse();
    check("rd_valid", {31'h0, valid}, 32'h0);
    check("rd_data", {24'h0, data}, 32'h11);
    rd_pulse();
    rd_pulse();
    check("rd2_data", {24'h0, data}, 32'h11);

    // Overrun.
    key_hold(8'h11, 8, 10);
    key_hold(8'h22, 8, 10);
    check("ovr_data", {24'h0, data}, 32'h22);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    rd_pulse();
    check("ovr_clr_valid", {31'h0, valid}, 32'h0);
    check("ovr_clr_flag", {31'h0, overrun}, 32'h0);

    // Read coincident with capture.
    key_hold(8'h66, 8, 10);
    sw = 8'h77;
    key_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rd = (i == 6);
    end
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check("coin_data", {24'h0, data}, 32'h77);
    check("coin_valid", {31'h0, valid}, 32'h1);
    check("coin_overrun", {31'h0, overrun}, 32'h0);

    // Random traffic, occasional mid-run reset.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 2) == 0) key_n = ~key_n;
      rd = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        check("rrst_valid", {31'h0, valid}, 32'h0);
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    rd = 1'b0;
    key_n = 1'b1;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
